uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
//  Reader end of the host-link byte FIFO: pops bytes from a show-ahead FIFO (read_data valid
//  whenever !empty) and serialises them as 8N1/8N2 UART frames on the TX pin. Sits between the
//  outbound FIFO (fed by the core's output packetiser) and the board UART/FTDI pin.
// PARAMETERS
//  DIVISOR    104  clk cycles per UART bit (e.g. 12 MHz / 115200); legal range >= 2
//  STOP_BITS  1    number of stop bits, 1 or 2; any other value is an elaboration error
// PORTS
//  clk               in   1  system clock; single clock domain
//  reset             in   1  synchronous, active-high reset
//  tx_enable         in   1  flow control; 0 = do not start a new frame (current frame completes)
//  fifo_empty        in   1  FIFO empty flag
//  fifo_read_data    in   8  FIFO head byte; valid whenever fifo_empty==0
//  fifo_read_enable  out  1  one-cycle pop strobe to the FIFO
//  serial_tx         out  1  UART line; idle high; registered
//  busy              out  1  1 while a frame is in progress (START..STOP)
//  tx_done           out  1  one-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  Reset values: serial_tx=1, busy=0, tx_done=0, fifo_read_enable=0, state=IDLE, counters=0.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE:  fifo_read_enable = (state==IDLE) && !fifo_empty && tx_enable (combinational, never
//          high outside IDLE, never high for more than 1 cycle per frame). On that cycle, latch
//          fifo_read_data into the shift register, load baud_cnt=DIVISOR-1, and go to START.
//   START: serial_tx=0 for DIVISOR cycles.
//   DATA:  8 bits, LSB first, DIVISOR cycles each; bit_cnt 3 bits counts 0..7.
//   STOP:  serial_tx=1 for STOP_BITS*DIVISOR cycles; tx_done pulses in the final cycle; -> IDLE.
//  Timing: if the pop happens in cycle N, serial_tx is low from cycle N+1. The frame occupies
//   (1+8+STOP_BITS)*DIVISOR cycles. IDLE lasts at least 1 cycle, so back-to-back frames have a
//   pop-to-pop period of (9+STOP_BITS)*DIVISOR+1 cycles.
//  Counters: baud_cnt is $clog2(DIVISOR) bits and counts down. Bit advance happens when
//   baud_cnt==0, and baud_cnt reloads to DIVISOR-1 on advance. For STOP_BITS==2, the stop phase
//   reuses bit_cnt to count 2 bit-times.
//  busy=1 from cycle N+1 through the last stop cycle inclusive; busy=0 in IDLE.
//  Boundary cases:
//   - fifo_empty asserted in IDLE: remain in IDLE, line high, no pop.
//   - fifo_empty changes during a frame: ignored, because the byte is already latched.
//   - tx_enable deasserted mid-frame: the frame completes normally and no new pop is issued
//     until tx_enable=1.
//   - tx_enable and !fifo_empty rising together: the pop occurs in that same cycle.
//   - reset mid-frame: next cycle serial_tx=1 and state=IDLE. The popped byte is discarded,
//     not re-read.
//   - Never pop while fifo_empty=1, even if tx_enable=1.
//  No framing gaps inside a frame; serial_tx never glitches because it is driven from a flop.
// STRUCTURE
//  uart_pkg (shared with the future uart_rx_fill):
//   - typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t
//   - localparam UART_DATA_BITS=8
//   - function baud_width(DIVISOR) returning $clog2(DIVISOR)
//  Sub-module uart_baud_gen: loadable down-counter with tick output (tick when count==0, reload
//   on load or tick), shared with the receiver. The FSM, shift register and pop logic are in
//   uart_tx_drain.
// TESTING (bench: DIVISOR=4, STOP_BITS=1 unless noted; FIFO model is show-ahead)
//  1. Reset, FIFO empty, 100 cycles -> serial_tx=1, busy=0, fifo_read_enable never 1.
//  2. Push 0xA5, tx_enable=1 -> 1 pop; line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles
//     (40 cycles total); tx_done pulses once in cycle 40.
//  3. Push 0x00,0xFF,0x55 -> 3 pops, each 41 cycles apart; decoded bytes match in order;
//     busy low exactly 1 cycle between frames.
//  4. STOP_BITS=2, push 0x3C -> 4-cycle start, 32 data cycles, 8 stop cycles high;
//     pop-to-pop period 45 cycles.
//  5. tx_enable=0 with 2 bytes queued -> no pop. Raise tx_enable, then drop it during data bit 3
//     -> first frame completes, and the second is not popped until tx_enable=1 again.
//  6. Assert reset during data bit 5 -> serial_tx=1 next cycle, busy=0, and FIFO count reduced
//     by 1 only. The next queued byte is sent as a complete frame after reset release.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers for the tx drain and rx fill
package uart_pkg;

    typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int baud_width(input int divisor);
        return $clog2(divisor);
    endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// rtl/uart_tx_drain_if.sv - FIFO read port, flow control and UART line of the tx drain
interface uart_tx_drain_if;

    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_read_data;
    logic       fifo_read_enable;
    logic       serial_tx;
    logic       busy;
    logic       tx_done;

    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_read_data,
        output fifo_read_enable,
        output serial_tx,
        output busy,
        output tx_done
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_read_data,
        input  fifo_read_enable,
        input  serial_tx,
        input  busy,
        input  tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - loadable baud down-counter, ticks at zero and reloads on load or tick
module uart_baud_gen #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] reload_value,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    assign tick = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load || tick) begin
            count <= reload_value;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - pops bytes from a show-ahead FIFO and sends them as 8N1/8N2 UART frames
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DIVISOR   = 104,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_drain_if.master bus
);

    localparam int            BW        = baud_width(DIVISOR);
    localparam logic [BW-1:0] RELOAD    = BW'(DIVISOR - 1);
    localparam logic [BW-1:0] LAST_TICK = BW'(1);
    localparam logic [2:0]    LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_drain: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t               state;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_cnt;
    logic                      serial_tx_q;
    logic                      busy_q;
    logic                      tx_done_q;
    logic                      pop;
    logic                      tick;
    logic [BW-1:0]             baud_cnt;

    // The pop doubles as the baud counter load so the start bit is exactly DIVISOR cycles.
    assign pop = (state == UART_IDLE) && !bus.fifo_empty && bus.tx_enable;

    uart_baud_gen #(.WIDTH(BW)) u_baud (
        .clk          (clk),
        .reset        (reset),
        .load         (pop),
        .reload_value (RELOAD),
        .tick         (tick),
        .count        (baud_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= UART_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            serial_tx_q <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state)
                UART_IDLE: begin
                    if (pop) begin
                        shift       <= bus.fifo_read_data;
                        bit_cnt     <= '0;
                        serial_tx_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= UART_START;
                    end
                end
                UART_START: begin
                    if (tick) begin
                        serial_tx_q <= shift[0];
                        shift       <= shift >> 1;
                        state       <= UART_DATA;
                    end
                end
                UART_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            serial_tx_q <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= UART_STOP;
                        end else begin
                            serial_tx_q <= shift[0];
                            shift       <= shift >> 1;
                            bit_cnt     <= bit_cnt + 3'd1;
                        end
                    end
                end
                UART_STOP: begin
                    // Registered one cycle early so the pulse lands on the final stop cycle.
                    if (bit_cnt == LAST_STOP && baud_cnt == LAST_TICK) begin
                        tx_done_q <= 1'b1;
                    end
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            busy_q <= 1'b0;
                            state  <= UART_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

    assign bus.fifo_read_enable = pop;
    assign bus.serial_tx        = serial_tx_q;
    assign bus.busy             = busy_q;
    assign bus.tx_done          = tx_done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - bench for uart_tx_drain, DIVISOR=4, instance 0 8N1 and instance 1 8N2
module tb_uart_tx_drain;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    bit         en [2];
    logic [7:0] q [2][$];
    int         pop_cyc [2][$];
    int         done_cyc [2][$];
    int         pos [2];
    bit         line0 [0:8191];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_drain_if ifc [2] ();

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, g, cyc, act, exp);
        end
    endtask

    // Expected line level k cycles into a frame (k=0 means idle).
    function automatic logic exp_line(input int k, input logic [7:0] b);
        int idx;
        if (k == 0) return 1'b1;
        idx = (k - 1) / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int FRAME = (10 + g) * DIV;
        logic [7:0] mbyte;

        uart_tx_drain #(.DIVISOR(DIV), .STOP_BITS(g + 1)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifc[g])
        );

        assign ifc[g].tx_enable = en[g];

        always @(posedge clk) begin
            if (ifc[g].fifo_read_enable === 1'b1 && q[g].size() > 0) void'(q[g].pop_front());
            ifc[g].fifo_empty     <= (q[g].size() == 0);
            ifc[g].fifo_read_data <= (q[g].size() > 0) ? q[g][0] : 8'h00;
        end

        always @(negedge clk) begin : model
            bit ep;
            if (chk) begin
                ep = (pos[g] == 0) && en[g] && (ifc[g].fifo_empty === 1'b0);
                check("pop", g, 32'(ifc[g].fifo_read_enable), 32'(ep));
                check("serial_tx", g, 32'(ifc[g].serial_tx), 32'(exp_line(pos[g], mbyte)));
                check("busy", g, 32'(ifc[g].busy), 32'(pos[g] != 0));
                check("tx_done", g, 32'(ifc[g].tx_done), 32'(pos[g] == FRAME));
                if (ifc[g].fifo_read_enable === 1'b1) pop_cyc[g].push_back(cyc);
                if (ifc[g].tx_done === 1'b1) done_cyc[g].push_back(cyc);
                if (g == 0) line0[cyc % 8192] = ifc[g].serial_tx;
                if (reset) pos[g] = 0;
                else if (pos[g] == 0) begin
                    if (ep) begin
                        pos[g] = 1;
                        mbyte  = ifc[g].fifo_read_data;
                    end
                end else pos[g] = (pos[g] == FRAME) ? 0 : pos[g] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int g, input bit done_q, input int want, input int budget,
                            input string name, output int at);
        int n;
        for (int i = 0; i < budget; i++) begin
            n = done_q ? done_cyc[g].size() : pop_cyc[g].size();
            if (n >= want) break;
            tick(1);
        end
        n = done_q ? done_cyc[g].size() : pop_cyc[g].size();
        vectors++;
        if (n < want) begin
            errors++;
            $display("FAIL %s inst%0d: timeout, got %0d events expected %0d", name, g, n, want);
            at = cyc;
        end else begin
            at = done_q ? done_cyc[g][want-1] : pop_cyc[g][want-1];
        end
    endtask

    initial begin
        int p, p2, p3, d, n0;
        logic [9:0] bits;

        en[0] = 1'b0;
        en[1] = 1'b0;
        pos[0] = 0;
        pos[1] = 0;
        tick(1);
        chk = 1'b1;
        tick(2);
        reset = 1'b0;

        // Empty FIFO: line idle, no pops.
        tick(100);
        check("t1_pops", 0, 32'(pop_cyc[0].size()), 32'd0);
        check("t1_line", 0, 32'(ifc[0].serial_tx), 32'd1);
        check("t1_busy", 0, 32'(ifc[0].busy), 32'd0);

        // Single 0xA5 frame.
        q[0].push_back(8'hA5);
        en[0] = 1'b1;
        wait_cnt(0, 1'b0, 1, 20, "t2_pop", p);
        wait_cnt(0, 1'b1, 1, 60, "t2_done", d);
        check("t2_done_offset", 0, 32'(d - p), 32'd40);
        for (int i = 0; i < 10; i++) bits[i] = line0[(p + 3 + DIV * i) % 8192];
        check("t2_frame_bits", 0, 32'(bits), 32'h34A);
        tick(5);

        // Back-to-back frames.
        n0 = pop_cyc[0].size();
        q[0].push_back(8'h00);
        q[0].push_back(8'hFF);
        q[0].push_back(8'h55);
        wait_cnt(0, 1'b0, n0 + 3, 200, "t3_pops", p3);
        p  = pop_cyc[0][n0];
        p2 = pop_cyc[0][n0+1];
        check("t3_period_a", 0, 32'(p2 - p), 32'd41);
        check("t3_period_b", 0, 32'(p3 - p2), 32'd41);
        wait_cnt(0, 1'b1, done_cyc[0].size() + 1, 200, "t3_done", d);
        while (ifc[0].busy) tick(1);
        tick(3);

        // Flow control.
        en[0] = 1'b0;
        n0 = pop_cyc[0].size();
        q[0].push_back(8'h12);
        q[0].push_back(8'h34);
        tick(50);
        check("t5_held", 0, 32'(pop_cyc[0].size()), 32'(n0));
        en[0] = 1'b1;
        wait_cnt(0, 1'b0, n0 + 1, 5, "t5_pop1", p);
        while (cyc < p + 18) tick(1);
        en[0] = 1'b0;
        wait_cnt(0, 1'b1, done_cyc[0].size() + 1, 60, "t5_done1", d);
        check("t5_done_offset", 0, 32'(d - p), 32'd40);
        tick(20);
        check("t5_no_second", 0, 32'(pop_cyc[0].size()), 32'(n0 + 1));
        en[0] = 1'b1;
        wait_cnt(0, 1'b0, n0 + 2, 3, "t5_pop2", p2);
        wait_cnt(0, 1'b1, done_cyc[0].size() + 1, 60, "t5_done2", d);
        tick(3);

        // Reset during data bit 5.
        n0 = pop_cyc[0].size();
        q[0].push_back(8'h9A);
        q[0].push_back(8'h6B);
        wait_cnt(0, 1'b0, n0 + 1, 5, "t6_pop1", p);
        while (cyc < p + 26) tick(1);
        reset = 1'b1;
        en[0] = 1'b0;
        tick(1);
        reset = 1'b0;
        check("t6_line", 0, 32'(ifc[0].serial_tx), 32'd1);
        check("t6_busy", 0, 32'(ifc[0].busy), 32'd0);
        check("t6_fifo_left", 0, 32'(q[0].size()), 32'd1);
        en[0] = 1'b1;
        wait_cnt(0, 1'b0, n0 + 2, 5, "t6_pop2", p2);
        wait_cnt(0, 1'b1, done_cyc[0].size() + 1, 60, "t6_done", d);
        check("t6_done_offset", 0, 32'(d - p2), 32'd40);
        check("t6_fifo_empty", 0, 32'(q[0].size()), 32'd0);

        // Two stop bits.
        q[1].push_back(8'h3C);
        q[1].push_back(8'h81);
        en[1] = 1'b1;
        wait_cnt(1, 1'b0, 2, 100, "t4_pops", p2);
        p = pop_cyc[1][0];
        check("t4_period", 1, 32'(p2 - p), 32'd45);
        check("t4_done_offset", 1, 32'(done_cyc[1][0] - p), 32'd44);

        // Randomised traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            for (int g = 0; g < 2; g++) begin
                if ($urandom_range(0, 5) == 0 && q[g].size() < 8) q[g].push_back(8'($urandom));
                if ($urandom_range(0, 39) == 0) en[g] = !en[g];
            end
            reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset = 1'b0;
        en[0] = 1'b1;
        en[1] = 1'b1;
        begin
            int budget;
            budget = 0;
            while ((q[0].size() != 0 || q[1].size() != 0 || pos[0] != 0 || pos[1] != 0) && budget < 3000) begin
                tick(1);
                budget++;
            end
            check("drain_timeout", 0, 32'(budget < 3000), 32'd1);
        end
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
